// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-based prefetch of 16-bit cells into a small FIFO, with
// branch redirect that flushes the buffer and drops the response to the redirect-edge request.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        icache_not_enable,
  output logic [31:0] icache_index,
  input  logic [15:0] icache_data,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic        decode_ready,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [31:0] instr_pc
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  logic [31:0]     inflight_pc_q, inflight_pc_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [15:0]     fifo_instr_q [FIFO_DEPTH];
  logic [15:0]     fifo_instr_d [FIFO_DEPTH];
  logic [31:0]     fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]     fifo_pc_d    [FIFO_DEPTH];

  logic [CntW-1:0] credit;
  logic            issue;
  logic            push;
  logic            pop;

  // Credits count outstanding requests too, so a push always finds a free slot.
  assign credit = count_q + CntW'(inflight_q);
  assign issue  = credit < CntW'(FIFO_DEPTH);

  assign icache_index      = fetch_pc_q;
  // Reset gating keeps the cache idle while reset is held; otherwise purely registered.
  assign icache_not_enable = reset | ~issue;

  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? fifo_instr_q[rd_ptr_q] : 16'h0000;
  assign instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q]    : 32'h0000_0000;

  assign push = inflight_q & ~branch_valid;
  assign pop  = instr_valid & decode_ready & ~branch_valid;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    fifo_instr_d  = fifo_instr_q;
    fifo_pc_d     = fifo_pc_q;

    if (branch_valid) begin
      // Clearing inflight drops the response to the request issued on this edge.
      fetch_pc_d = branch_target;
      inflight_d = 1'b0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + 32'd1;
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
      end else begin
        inflight_d = 1'b0;
      end

      if (push) begin
        fifo_instr_d[wr_ptr_q] = icache_data;
        fifo_pc_d[wr_ptr_q]    = inflight_pc_q;
        wr_ptr_d               = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end

      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0000_0000;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr_q[i] <= 16'h0000;
        fifo_pc_q[i]    <= 32'h0000_0000;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      fifo_instr_q  <= fifo_instr_d;
      fifo_pc_q     <= fifo_pc_d;
    end
  end

endmodule
